param_queue: RTL and testbench
==============================

# param_queue

Parametrised FIFO queue, the next generation of the team's 8×8-bit queue: configurable data width and depth, a circular buffer with read/write pointers in place of the shift register, level flags with programmable thresholds, sticky error flags, a synchronous flush, and an optional overwrite-oldest mode. It sits in the `clk_10khz` domain between producer and consumer logic. It keeps the established enqueue/ack/dequeue/len handshake, so existing users can switch to it with the default parameters.

## Interface
Parameters:
- `WIDTH`, 8, data bits per element (≥1)
- `DEPTH`, 8, number of elements (≥2); power of two not required
- `AF_LEVEL`, DEPTH-1, `almost_full_out` asserts when count ≥ AF_LEVEL
- `AE_LEVEL`, 1, `almost_empty_out` asserts when count ≤ AE_LEVEL
- `OVERWRITE`, 0, 1 = enqueue into a full queue drops the oldest element and accepts the new one

Ports:
- `clk_10khz`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `flush`  in  1  synchronous clear of contents and sticky flags
- `data_in`  in  WIDTH  element to enqueue
- `enqueue_in`  in  1  enqueue request, sampled each edge
- `dequeue_in`  in  1  dequeue request, sampled each edge
- `ack_in`  out  1  registered; 1 for the cycle after an accepted enqueue
- `data_out`  out  WIDTH  registered; last dequeued element, held until the next dequeue
- `data_valid_out`  out  1  registered; 1 for the cycle after an accepted dequeue
- `len_out`  out  $clog2(DEPTH+1)  current element count, 0..DEPTH
- `full_out`, `empty_out`  out  1  count==DEPTH, count==0
- `almost_full_out`, `almost_empty_out`  out  1  threshold flags
- `overflow_out`, `underflow_out`  out  1  sticky error flags

## Operation
- Storage is DEPTH×WIDTH. `wr_ptr` and `rd_ptr` each wrap DEPTH-1→0. `count` is an explicit register.
- Enqueue is accepted when `enqueue_in` && (!full || dequeue accepted the same cycle || OVERWRITE). On accept: mem[wr_ptr]←data_in, wr_ptr advances.
- Dequeue is accepted when `dequeue_in` && !empty. On accept: data_out←mem[rd_ptr], rd_ptr advances. There is no bypass from an empty queue.
- Simultaneous requests:
  - Full, both requests: both accepted. The oldest element goes out, the new one is written, count is unchanged.
  - Empty, both requests: only the enqueue is accepted. underflow_out sets and count becomes 1.
  - Otherwise, both requests: both accepted and count is unchanged.
- Enqueue into a full queue without a dequeue:
  - OVERWRITE=0: rejected. ack_in=0, overflow_out sets.
  - OVERWRITE=1: accepted. rd_ptr advances, ack_in=1, count stays DEPTH, overflow_out sets. data_out and data_valid_out are unaffected.
- Dequeue on empty: rejected. data_valid_out=0, data_out holds, underflow_out sets.
- `flush` takes priority over everything else. Pointers, count, overflow_out and underflow_out clear; ack_in=0 and data_valid_out=0; same-cycle requests are ignored; data_out holds.
- Arithmetic: pointer wrap uses a compare to DEPTH-1, never modulo truncation. count never leaves 0..DEPTH.

## Timing
- All state changes on the rising edge of `clk_10khz`. Enqueue/dequeue effects appear on `len_out` and the flags one cycle after the request edge.
- Dequeue latency is 1 cycle: data_out and data_valid_out update on the edge that samples dequeue_in.
- Ack latency is 1 cycle. Back-to-back requests every cycle are sustained with no bubbles.
- `len_out`, full/empty and the almost flags decode only the count register, so they are glitch-free.
- Reset values: ack_in=0, data_out=0, data_valid_out=0, len_out=0, full_out=0, empty_out=1, almost_full_out=(AF_LEVEL==0), almost_empty_out=1, overflow_out=0, underflow_out=0. Pointers are 0; storage clears to 0.
- Reset asserted mid-operation forces these values immediately, regardless of the clock. The first request is accepted on the first edge after deassertion.

## Structure
- `param_queue_pkg`: default parameter constants and a count-width function (DEPTH → $clog2(DEPTH+1)).
- Sub-module `queue_ptr`: a pointer register with enable and flush, wrapping at DEPTH-1. It is instantiated twice (read and write).
- Storage, count and flags live in `param_queue`.

## Test plan
- Reset, then enqueue 0x11..0x18 on 8 consecutive cycles (defaults) → ack_in high 8 cycles, len_out=8, full_out=1, almost_full_out from len 7. Then dequeue 8× → data_out 0x11..0x18 in order, empty_out=1.
- Full queue, enqueue 0xAA + dequeue in the same cycle → data_out=0x11, len_out stays 8, 0xAA emerges last.
- Full queue, enqueue 0x55 alone: OVERWRITE=0 → ack_in=0, overflow_out=1, contents unchanged. OVERWRITE=1 → ack_in=1, oldest dropped, 0x55 emerges last.
- Empty queue, dequeue alone → underflow_out=1, data_valid_out=0. Enqueue+dequeue together → len_out=1, underflow_out=1.
- DEPTH=5, WIDTH=12: 13 enqueue/dequeue interleaved cycles wrapping pointers twice → FIFO order preserved, len_out never exceeds 5.
- Flush with len_out=4 and enqueue asserted → len_out=0, empty_out=1, ack_in=0, sticky flags cleared. Async reset pulse mid-burst → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/param_queue_pkg.sv
// rtl/param_queue_pkg.sv - default parameters and width helpers for param_queue
package param_queue_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AE_LEVEL  = 1;
  localparam bit DEF_OVERWRITE = 1'b0;

  // Bits needed to hold an element count of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth slots; never less than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/queue_ptr.sv
// rtl/queue_ptr.sv - circular buffer pointer with enable and flush, wraps at DEPTH-1
module queue_ptr
  import param_queue_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  // Explicit compare so non-power-of-two depths wrap correctly.
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Pointer register: flush beats advance; advance wraps from LAST to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/param_queue.sv
// rtl/param_queue.sv - parametrised circular-buffer FIFO with level and sticky error flags
module param_queue
  import param_queue_pkg::*;
#(
  parameter int  WIDTH     = DEF_WIDTH,
  parameter int  DEPTH     = DEF_DEPTH,
  parameter int  AF_LEVEL  = DEPTH - 1,
  parameter int  AE_LEVEL  = DEF_AE_LEVEL,
  parameter bit  OVERWRITE = DEF_OVERWRITE,
  localparam int CW        = count_width(DEPTH)
) (
  input  logic             clk_10khz,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enqueue_in,
  input  logic             dequeue_in,
  output logic             ack_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid_out,
  output logic [CW-1:0]    len_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             almost_full_out,
  output logic             almost_empty_out,
  output logic             overflow_out,
  output logic             underflow_out
);

  localparam int            PW      = ptr_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  logic is_full;
  logic is_empty;
  logic deq_acc;
  logic enq_acc;
  logic drop_oldest;
  logic rd_adv;
  logic ovf_evt;
  logic udf_evt;

  // Request arbitration: decide what is accepted this edge from the current count.
  always_comb begin
    is_full     = (count_q == DEPTH_C);
    is_empty    = (count_q == '0);
    deq_acc     = dequeue_in && !is_empty && !flush;
    // A same-cycle dequeue frees a slot, so a full queue can still take a write.
    enq_acc     = enqueue_in && !flush && (!is_full || deq_acc || OVERWRITE);
    // Overwrite of a full queue with no dequeue silently retires the oldest slot.
    drop_oldest = enq_acc && is_full && !deq_acc;
    rd_adv      = deq_acc || drop_oldest;
    ovf_evt     = enqueue_in && is_full && !deq_acc && !flush;
    udf_evt     = dequeue_in && is_empty && !flush;
  end

  queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk_10khz),
    .rst   (reset),
    .flush (flush),
    .en    (enq_acc),
    .ptr   (wr_ptr)
  );

  queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk_10khz),
    .rst   (reset),
    .flush (flush),
    .en    (rd_adv),
    .ptr   (rd_ptr)
  );

  // Storage write; contents are not cleared by flush, only made unreachable.
  always_ff @(posedge clk_10khz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enq_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Element count: changes only when exactly one side takes effect on the depth.
  always_ff @(posedge clk_10khz or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (enq_acc && !deq_acc && !is_full) begin
      count_q <= count_q + CW'(1);
    end else if (deq_acc && !enq_acc) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Handshake outputs: one-cycle ack/valid pulses, data_out holds the last read.
  always_ff @(posedge clk_10khz or posedge reset) begin
    if (reset) begin
      ack_in         <= 1'b0;
      data_valid_out <= 1'b0;
      data_out       <= '0;
    end else begin
      ack_in         <= enq_acc;
      data_valid_out <= deq_acc;
      if (deq_acc) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge clk_10khz or posedge reset) begin
    if (reset) begin
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else if (flush) begin
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      if (ovf_evt) overflow_out  <= 1'b1;
      if (udf_evt) underflow_out <= 1'b1;
    end
  end

  // Level flags decode the count register only, so they never glitch.
  always_comb begin
    len_out          = count_q;
    full_out         = is_full;
    empty_out        = is_empty;
    almost_full_out  = int'(count_q) >= AF_LEVEL;
    almost_empty_out = int'(count_q) <= AE_LEVEL;
  end

endmodule

// File: tb/tb_param_queue.sv
// tb/tb_param_queue.sv - directed self-checking bench for param_queue
module tb_param_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A: defaults.
  logic       a_flush = 0, a_enq = 0, a_deq = 0;
  logic [7:0] a_din = 0, a_dout;
  logic       a_ack, a_dv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [3:0] a_len;

  // Instance B: overwrite mode.
  logic       b_flush = 0, b_enq = 0, b_deq = 0;
  logic [7:0] b_din = 0, b_dout;
  logic       b_ack, b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [3:0] b_len;

  // Instance C: DEPTH=5, WIDTH=12.
  logic        c_flush = 0, c_enq = 0, c_deq = 0;
  logic [11:0] c_din = 0, c_dout;
  logic        c_ack, c_dv, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
  logic [2:0]  c_len;

  param_queue u_a (
    .clk_10khz(clk), .reset(rst), .flush(a_flush), .data_in(a_din),
    .enqueue_in(a_enq), .dequeue_in(a_deq), .ack_in(a_ack), .data_out(a_dout),
    .data_valid_out(a_dv), .len_out(a_len), .full_out(a_full), .empty_out(a_empty),
    .almost_full_out(a_af), .almost_empty_out(a_ae), .overflow_out(a_ovf),
    .underflow_out(a_udf)
  );

  param_queue #(.OVERWRITE(1'b1)) u_b (
    .clk_10khz(clk), .reset(rst), .flush(b_flush), .data_in(b_din),
    .enqueue_in(b_enq), .dequeue_in(b_deq), .ack_in(b_ack), .data_out(b_dout),
    .data_valid_out(b_dv), .len_out(b_len), .full_out(b_full), .empty_out(b_empty),
    .almost_full_out(b_af), .almost_empty_out(b_ae), .overflow_out(b_ovf),
    .underflow_out(b_udf)
  );

  param_queue #(.WIDTH(12), .DEPTH(5)) u_c (
    .clk_10khz(clk), .reset(rst), .flush(c_flush), .data_in(c_din),
    .enqueue_in(c_enq), .dequeue_in(c_deq), .ack_in(c_ack), .data_out(c_dout),
    .data_valid_out(c_dv), .len_out(c_len), .full_out(c_full), .empty_out(c_empty),
    .almost_full_out(c_af), .almost_empty_out(c_ae), .overflow_out(c_ovf),
    .underflow_out(c_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [11:0] mq[$];
  logic [11:0] exp_c;
  logic        c_deq_ok, c_enq_ok;

  initial begin
    // Reset values
    #20;
    check("rst_ack", a_ack, 0);
    check("rst_dout", a_dout, 0);
    check("rst_dv", a_dv, 0);
    check("rst_len", a_len, 0);
    check("rst_full", a_full, 0);
    check("rst_empty", a_empty, 1);
    check("rst_af", a_af, 0);
    check("rst_ae", a_ae, 1);
    check("rst_ovf", a_ovf, 0);
    check("rst_udf", a_udf, 0);
    #100 rst = 1'b0;

    // Fill 0x11..0x18
    for (int i = 0; i < 8; i++) begin
      a_enq = 1; a_din = 8'h11 + 8'(i);
      tick;
      check("fill_ack", a_ack, 1);
      check("fill_len", a_len, i + 1);
      check("fill_af", a_af, (i + 1) >= 7);
      check("fill_ae", a_ae, (i + 1) <= 1);
      check("fill_full", a_full, (i + 1) == 8);
    end

    // Full, enqueue 0xAA with dequeue
    a_din = 8'hAA; a_deq = 1;
    tick;
    check("both_full_dout", a_dout, 8'h11);
    check("both_full_dv", a_dv, 1);
    check("both_full_ack", a_ack, 1);
    check("both_full_len", a_len, 8);

    // Full, enqueue 0x55 alone is rejected
    a_din = 8'h55; a_deq = 0;
    tick;
    check("ovf_ack", a_ack, 0);
    check("ovf_flag", a_ovf, 1);
    check("ovf_len", a_len, 8);
    check("ovf_dv", a_dv, 0);

    // Drain: 0x12..0x18 then 0xAA
    a_enq = 0; a_deq = 1;
    for (int i = 0; i < 8; i++) begin
      tick;
      check("drain_dout", a_dout, (i < 7) ? 32'h12 + 32'(i) : 32'hAA);
      check("drain_dv", a_dv, 1);
    end
    a_deq = 0;
    tick;
    check("drain_empty", a_empty, 1);
    check("drain_len", a_len, 0);
    check("drain_dv_low", a_dv, 0);
    check("ovf_sticky", a_ovf, 1);

    // Empty, dequeue alone
    a_deq = 1;
    tick;
    check("udf_flag", a_udf, 1);
    check("udf_dv", a_dv, 0);
    check("udf_dout_hold", a_dout, 8'hAA);

    // Empty, enqueue + dequeue: only the enqueue lands
    a_enq = 1; a_din = 8'h33;
    tick;
    check("empty_both_len", a_len, 1);
    check("empty_both_ack", a_ack, 1);
    check("empty_both_dv", a_dv, 0);
    check("empty_both_udf", a_udf, 1);
    a_deq = 0;

    // Bring to len 4, then flush with enqueue asserted
    for (int i = 0; i < 3; i++) begin
      a_din = 8'h34 + 8'(i);
      tick;
    end
    check("pre_flush_len", a_len, 4);
    a_flush = 1; a_din = 8'h99;
    tick;
    check("flush_len", a_len, 0);
    check("flush_empty", a_empty, 1);
    check("flush_ack", a_ack, 0);
    check("flush_ovf", a_ovf, 0);
    check("flush_udf", a_udf, 0);
    check("flush_dout", a_dout, 8'hAA);
    a_flush = 0; a_enq = 0;
    tick;
    check("post_flush_len", a_len, 0);

    // Overwrite mode: fill 0x01..0x08, then 0x55 alone drops 0x01
    for (int i = 0; i < 8; i++) begin
      b_enq = 1; b_din = 8'h01 + 8'(i);
      tick;
    end
    check("ow_full", b_full, 1);
    b_din = 8'h55;
    tick;
    check("ow_ack", b_ack, 1);
    check("ow_ovf", b_ovf, 1);
    check("ow_len", b_len, 8);
    check("ow_dv", b_dv, 0);
    check("ow_dout", b_dout, 0);
    b_enq = 0; b_deq = 1;
    for (int i = 0; i < 8; i++) begin
      tick;
      check("ow_drain", b_dout, (i < 7) ? 32'h02 + 32'(i) : 32'h55);
    end
    b_deq = 0;
    tick;
    check("ow_empty", b_empty, 1);

    // DEPTH=5: 13 interleaved cycles then drain, pointers wrap twice
    for (int k = 0; k < 18; k++) begin
      c_enq = (k < 13);
      c_deq = (k >= 5);
      c_din = 12'hA00 + 12'(k);
      c_deq_ok = c_deq && (mq.size() > 0);
      c_enq_ok = c_enq && ((mq.size() < 5) || c_deq_ok);
      exp_c = 12'h0;
      if (c_deq_ok) exp_c = mq.pop_front();
      if (c_enq_ok) mq.push_back(c_din);
      tick;
      check("c_len", c_len, mq.size());
      check("c_len_max", c_len <= 3'd5, 1);
      check("c_ack", c_ack, c_enq_ok);
      check("c_dv", c_dv, c_deq_ok);
      if (c_deq_ok) check("c_dout", c_dout, exp_c);
    end
    c_enq = 0; c_deq = 0;
    tick;
    check("c_empty", c_empty, 1);
    check("c_udf", c_udf, 0);

    // Async reset mid-burst
    a_enq = 1; a_din = 8'h41;
    tick;
    a_din = 8'h42;
    tick;
    a_deq = 1; a_din = 8'h43;
    tick;
    check("burst_dv", a_dv, 1);
    #20 rst = 1'b1;
    #5;
    check("arst_ack", a_ack, 0);
    check("arst_dout", a_dout, 0);
    check("arst_dv", a_dv, 0);
    check("arst_len", a_len, 0);
    check("arst_empty", a_empty, 1);
    check("arst_ae", a_ae, 1);
    #10 rst = 1'b0;
    a_deq = 0; a_din = 8'h77;
    tick;
    check("post_rst_ack", a_ack, 1);
    check("post_rst_len", a_len, 1);
    a_enq = 0; a_deq = 1;
    tick;
    check("post_rst_dout", a_dout, 8'h77);
    check("post_rst_dv", a_dv, 1);
    a_deq = 0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
